term_writer: RTL

- Producer side of the character-buffer write port (w_h_addr / w_v_addr / w_data / w_en) feeding the font terminal.
- Accepts a valid/ready stream of 8-bit ASCII bytes. Keeps a text cursor and converts printable characters to 6-bit font codes.
- Interprets control characters (LF, CR, BS, FF).
- Clears the screen after reset and clears each new line on advance, so stale glyphs never show on the VGA display.

---
 rtl/term_writer_pkg.sv | 30 +++
 rtl/term_writer_ascii_to_font.sv | 28 ++
 rtl/term_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/term_writer_pkg.sv
// term_writer_pkg: definitions shared by the terminal writer.
//   - FSM state encoding (idle, full-screen clear, single-line clear)
//   - ASCII control bytes the writer interprets (BS, LF, FF, CR)
//   - font codes for a blank cell and for the '?' substitute glyph
//   - default screen geometry (80 x 60 cells of 8x8 px on 640x480)
//   - wrap_inc: increment that wraps to zero after a given last value
package term_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_SCREEN = 2'd1,
    ST_CLR_LINE   = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam logic [5:0] FONT_SPACE = 6'h00;
  localparam logic [5:0] FONT_QMARK = 6'h1F;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] last);
    return (v == last) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/term_writer_ascii_to_font.sv
// term_writer_ascii_to_font: combinational ASCII byte to 6-bit font code.
// Ports:
//   char_i      [7:0] ASCII byte
//   code_o      [5:0] font code (0x00 = space ... 0x3F = '_')
//   printable_o       byte is a glyph (>= 0x20) rather than a control byte
// Lowercase letters fold onto uppercase; every byte without its own glyph
// (0x60, 0x7B..0xFF) is shown as '?'.
module term_writer_ascii_to_font
  import term_writer_pkg::*;
(
  input  logic [7:0] char_i,
  output logic [5:0] code_o,
  output logic       printable_o
);

  always_comb begin
    printable_o = (char_i >= 8'h20);
    code_o      = FONT_SPACE;
    if (char_i >= 8'h20 && char_i <= 8'h5F) begin
      code_o = 6'(char_i - 8'h20);
    end else if (char_i >= 8'h61 && char_i <= 8'h7A) begin
      code_o = 6'(char_i - 8'h40);
    end else if (char_i >= 8'h20) begin
      code_o = FONT_QMARK;
    end
  end

endmodule

// File: rtl/term_writer.sv
// term_writer: producer side of the character-buffer write port.
// Accepts a valid/ready stream of ASCII bytes, tracks a text cursor and
// writes font codes into the character buffer. Interprets LF, CR, BS, FF.
// The screen is swept clear after reset and on FF, and each newly entered
// row is swept clear, so no stale glyphs remain visible.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_char/in_valid    input byte stream; in_ready high only in idle
//   w_h_addr/w_v_addr   buffer column/row of the current write
//   w_data/w_en         font code and one-cycle write strobe
//   cur_h/cur_v         cursor column/row
//   busy                a clear sweep is running
module term_writer
  import term_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] w_h_addr,
  output logic [7:0] w_v_addr,
  output logic [5:0] w_data,
  output logic       w_en,
  output logic [7:0] cur_h,
  output logic [7:0] cur_v,
  output logic       busy
);

  localparam logic [7:0] COL_LAST = 8'(COLS - 1);
  localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;          // sweep column
  logic [7:0] sv_q, sv_d;          // sweep row (screen clear only)
  logic [7:0] cur_h_q, cur_h_d;
  logic [7:0] cur_v_q, cur_v_d;
  logic [7:0] w_h_q, w_h_d;
  logic [7:0] w_v_q, w_v_d;
  logic [5:0] w_data_q, w_data_d;
  logic       w_en_q, w_en_d;

  logic [5:0] font_code;
  logic       font_printable;
  logic       accept;
  logic       screen_last;
  logic       line_last;

  term_writer_ascii_to_font u_font (
    .char_i      (in_char),
    .code_o      (font_code),
    .printable_o (font_printable)
  );

  assign accept      = in_valid && (state_q == ST_IDLE);
  assign screen_last = (sh_q == COL_LAST) && (sv_q == ROW_LAST);
  assign line_last   = (sh_q == COL_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLR_SCREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (font_printable) begin
            if (cur_h_q == COL_LAST) state_d = ST_CLR_LINE;
          end else if (in_char == ASCII_LF) begin
            state_d = ST_CLR_LINE;
          end else if (in_char == ASCII_FF) begin
            state_d = ST_CLR_SCREEN;
          end
        end
      end
      ST_CLR_SCREEN: if (screen_last) state_d = ST_IDLE;
      ST_CLR_LINE:   if (line_last) state_d = ST_IDLE;
      default:       state_d = ST_CLR_SCREEN;
    endcase
  end

  // Cursor, sweep counters and write-port next values
  always_comb begin
    sh_d     = sh_q;
    sv_d     = sv_q;
    cur_h_d  = cur_h_q;
    cur_v_d  = cur_v_q;
    w_h_d    = w_h_q;
    w_v_d    = w_v_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (font_printable) begin
            w_en_d   = 1'b1;
            w_h_d    = cur_h_q;
            w_v_d    = cur_v_q;
            w_data_d = font_code;
            if (cur_h_q == COL_LAST) begin
              // glyph lands in the last column; the next row is cleared after it
              cur_h_d = 8'd0;
              cur_v_d = wrap_inc(cur_v_q, ROW_LAST);
              sh_d    = 8'd0;
            end else begin
              cur_h_d = cur_h_q + 8'd1;
            end
          end else begin
            case (in_char)
              ASCII_LF: begin
                cur_h_d = 8'd0;
                cur_v_d = wrap_inc(cur_v_q, ROW_LAST);
                sh_d    = 8'd0;
              end
              ASCII_CR: cur_h_d = 8'd0;
              ASCII_BS: begin
                if (cur_h_q != 8'd0) begin
                  cur_h_d  = cur_h_q - 8'd1;
                  w_en_d   = 1'b1;
                  w_h_d    = cur_h_q - 8'd1;
                  w_v_d    = cur_v_q;
                  w_data_d = FONT_SPACE;
                end
              end
              ASCII_FF: begin
                cur_h_d = 8'd0;
                cur_v_d = 8'd0;
                sh_d    = 8'd0;
                sv_d    = 8'd0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLR_SCREEN: begin
        w_en_d   = 1'b1;
        w_h_d    = sh_q;
        w_v_d    = sv_q;
        w_data_d = FONT_SPACE;
        sh_d     = wrap_inc(sh_q, COL_LAST);
        if (line_last) sv_d = wrap_inc(sv_q, ROW_LAST);
        if (screen_last) begin
          cur_h_d = 8'd0;
          cur_v_d = 8'd0;
        end
      end
      ST_CLR_LINE: begin
        w_en_d   = 1'b1;
        w_h_d    = sh_q;
        w_v_d    = cur_v_q;
        w_data_d = FONT_SPACE;
        sh_d     = wrap_inc(sh_q, COL_LAST);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= 8'd0;
      sv_q     <= 8'd0;
      cur_h_q  <= 8'd0;
      cur_v_q  <= 8'd0;
      w_h_q    <= 8'd0;
      w_v_q    <= 8'd0;
      w_data_q <= 6'd0;
      w_en_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      sv_q     <= sv_d;
      cur_h_q  <= cur_h_d;
      cur_v_q  <= cur_v_d;
      w_h_q    <= w_h_d;
      w_v_q    <= w_v_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign w_h_addr = w_h_q;
  assign w_v_addr = w_v_q;
  assign w_data   = w_data_q;
  assign w_en     = w_en_q;
  assign cur_h    = cur_h_q;
  assign cur_v    = cur_v_q;

endmodule
